// File: rtl/qtree_arg_sequencer_pkg.sv
// rtl/qtree_arg_sequencer_pkg.sv - shared types and helpers for the QTree argument sequencer
// Purpose: QTree token width/type, skid occupancy state encoding, lane wrap helper.
// Ports: none (package).
package qtree_arg_sequencer_pkg;

  localparam int QTREE_W = 67;

  typedef logic [QTREE_W-1:0] QTree_Int_t;

  // Occupancy of the 2-entry output skid buffer; doubles as its state.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Next operand lane, wrapping after the last one.
  function automatic int next_lane(input int cur, input int num_lanes);
    return (cur >= num_lanes - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/qtree_skid_buf.sv
// rtl/qtree_skid_buf.sv - 2-entry registered skid buffer, order preserving
// Purpose: decouples upstream ready from downstream ready; full throughput.
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   s_tdata/s_tvalid       upstream word and valid
//   s_tready               registered "has space" (count < 2), 0 in reset
//   m_tdata/m_tvalid       head word, valid whenever the buffer is non-empty
//   m_tready               downstream ready
module qtree_skid_buf
  import qtree_arg_sequencer_pkg::*;
#(
  parameter int WIDTH = 68
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic             space_q;
  logic             push, pop;

  assign push = s_tvalid && space_q;
  assign pop  = (state_q != SKID_EMPTY) && m_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= SKID_EMPTY;
      entry0_q <= '0;
      entry1_q <= '0;
      space_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      // Space is a pure register so s_tready never depends on m_tready combinationally.
      space_q  <= (state_d != SKID_FULL);
    end
  end

  // entry0 is always the head; entry1 only holds the overflow word while stalled.
  always_comb begin
    state_d  = state_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          entry0_d = s_tdata;
          state_d  = SKID_ONE;
        end
      end
      SKID_ONE: begin
        case ({push, pop})
          2'b10: begin
            entry1_d = s_tdata;
            state_d  = SKID_FULL;
          end
          2'b01:   state_d  = SKID_EMPTY;
          2'b11:   entry0_d = s_tdata;
          default: state_d  = SKID_ONE;
        endcase
      end
      SKID_FULL: begin
        // No push possible here: space_q is low whenever the buffer is full.
        if (pop) begin
          entry0_d = entry1_q;
          state_d  = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  assign s_tready = space_q;
  assign m_tvalid = (state_q != SKID_EMPTY);
  assign m_tdata  = entry0_q;

endmodule

// File: rtl/qtree_arg_sequencer.sv
// rtl/qtree_arg_sequencer.sv - merges NUM_ARGS QTree operand streams in lane order
// Purpose: forwards one frame per lane, lanes 0..NUM_ARGS-1 then wraps, through a skid buffer.
// Optional: QTREE_SEQ_STATS_EN builds job/token counters; otherwise they read 0.
// Ports:
//   aclk, aresetn                 clock, synchronous active-low reset
//   s_tdata/s_tvalid/s_tlast      per-lane operand streams (lane k at s_tdata[k*QTREE_W +: QTREE_W])
//   s_tready                      per-lane ready, only the selected lane can be high
//   m_tdata/m_tlast/m_tvalid      merged stream out, m_tready in
//   o_job_cnt/o_tok_cnt           completed jobs / tokens accepted in the current job
module qtree_arg_sequencer #(
  parameter int NUM_ARGS = 3,
  parameter int QTREE_W  = qtree_arg_sequencer_pkg::QTREE_W,
  parameter int CNT_W    = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_ARGS*QTREE_W-1:0] s_tdata,
  input  logic [NUM_ARGS-1:0]        s_tvalid,
  input  logic [NUM_ARGS-1:0]        s_tlast,
  output logic [NUM_ARGS-1:0]        s_tready,
  output logic [QTREE_W-1:0]         m_tdata,
  output logic                       m_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [CNT_W-1:0]           o_job_cnt,
  output logic [CNT_W-1:0]           o_tok_cnt
);

  import qtree_arg_sequencer_pkg::*;

  localparam int SEL_W = $clog2(NUM_ARGS);
  typedef logic [SEL_W-1:0] arg_sel_t;

  arg_sel_t             sel_q, sel_d;
  logic [QTREE_W-1:0]   sel_tdata;
  logic                 sel_tvalid;
  logic                 sel_tlast;
  logic                 skid_space;
  logic                 accept;
  logic [QTREE_W:0]     skid_out;

  // Lane mux; the loop keeps an out-of-range sel from indexing past the bus.
  always_comb begin
    sel_tdata  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int k = 0; k < NUM_ARGS; k++) begin
      if (sel_q == arg_sel_t'(k)) begin
        sel_tdata  = s_tdata[k*QTREE_W +: QTREE_W];
        sel_tvalid = s_tvalid[k];
        sel_tlast  = s_tlast[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_ARGS; k++) begin
      s_tready[k] = (sel_q == arg_sel_t'(k)) && skid_space;
    end
  end

  assign accept = sel_tvalid && skid_space;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  // Advance on the accepted tlast so the next lane can be taken on the very next cycle.
  always_comb begin
    sel_d = sel_q;
    if (accept && sel_tlast) begin
      sel_d = arg_sel_t'(next_lane(int'(sel_q), NUM_ARGS));
    end
  end

  qtree_skid_buf #(
    .WIDTH (QTREE_W + 1)
  ) u_skid (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tdata  ({sel_tlast, sel_tdata}),
    .s_tvalid (sel_tvalid),
    .s_tready (skid_space),
    .m_tdata  (skid_out),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready)
  );

  assign m_tdata = skid_out[QTREE_W-1:0];
  assign m_tlast = skid_out[QTREE_W];

`ifdef QTREE_SEQ_STATS_EN
  logic             job_done;
  logic [CNT_W-1:0] job_cnt_q;
  logic [CNT_W-1:0] tok_cnt_q;

  assign job_done = accept && sel_tlast && (sel_q == arg_sel_t'(NUM_ARGS - 1));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      job_cnt_q <= '0;
      tok_cnt_q <= '0;
    end else if (job_done) begin
      job_cnt_q <= job_cnt_q + CNT_W'(1);
      tok_cnt_q <= '0;
    end else if (accept) begin
      tok_cnt_q <= tok_cnt_q + CNT_W'(1);
    end
  end

  assign o_job_cnt = job_cnt_q;
  assign o_tok_cnt = tok_cnt_q;
`else
  assign o_job_cnt = '0;
  assign o_tok_cnt = '0;
`endif

endmodule
